// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: RV32I load/store encodings, data-master FSM states and lane helpers.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} dm_state_t;

    function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3)
            F3_B, F3_BU: return 4'b0001 << a;
            F3_H, F3_HU: return 4'b0011 << a;
            default:     return 4'b1111;
        endcase
    endfunction

    // Undefined funct3 encodings are trapped the same way as misaligned ones.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return a[0];
            F3_W:        return |a;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] funct3, input logic [31:0] w);
        case (funct3)
            F3_B, F3_BU: return {4{w[7:0]}};
            F3_H, F3_HU: return {2{w[15:0]}};
            default:     return w;
        endcase
    endfunction

endpackage

// File: rtl/avalon_data_master_if.sv
// avalon_data_master_if: pipeline request side plus Avalon-MM data bus of the data master.
interface avalon_data_master_if #(parameter int ADDR_W = 32);

    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              start;
    logic              done;
    logic [31:0]       rdata_out;
    logic              err;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  avm_readdata, avm_waitrequest, avm_readdatavalid,
        output start, done, rdata_out, err,
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output avm_readdata, avm_waitrequest, avm_readdatavalid,
        input  start, done, rdata_out, err,
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
    );

endinterface

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half out of a bus word and sign/zero-extends it.
module load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] readdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = 8'(readdata_i >> {addr_i, 3'b000});
    assign h = 16'(readdata_i >> {addr_i[1], 4'b0000});

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{b[7]}}, b};
            F3_BU:   data_o = {24'b0, b};
            F3_H:    data_o = {{16{h[15]}}, h};
            F3_HU:   data_o = {16'b0, h};
            default: data_o = readdata_i;
        endcase
    end

endmodule

// File: rtl/avalon_data_master.sv
// avalon_data_master: runs one MEM-stage load/store as a single Avalon-MM transaction,
// with lane steering, load extension, misalignment trap and a bus watchdog.
module avalon_data_master
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    avalon_data_master_if.master dm_io
);

    dm_state_t         state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       ext;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              cap, busy, timeout;

    assign busy    = state_q == REQ || state_q == WAIT_RD;
    assign timeout = busy && cnt_q == 8'(TIMEOUT - 1);

    load_align u_load_align (
        .readdata_i(dm_io.avm_readdata),
        .funct3_i  (funct3_q),
        .addr_i    (addr_q[1:0]),
        .data_o    (ext)
    );

    // The watchdog wins over a same-cycle accept or readdatavalid: the command is withdrawn.
    always_comb begin
        state_d         = state_q;
        err_d           = err_q;
        rdata_d         = rdata_q;
        cnt_d           = busy ? cnt_q + 8'd1 : cnt_q;
        cap             = 1'b0;
        dm_io.avm_read  = 1'b0;
        dm_io.avm_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_io.req_valid) begin
                    cap     = 1'b1;
                    cnt_d   = 8'd0;
                    err_d   = misaligned(dm_io.req_funct3, dm_io.req_addr[1:0]);
                    state_d = misaligned(dm_io.req_funct3, dm_io.req_addr[1:0]) ? DONE : REQ;
                end
            end
            REQ: begin
                dm_io.avm_read  = !we_q && !timeout;
                dm_io.avm_write = we_q && !timeout;
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (!dm_io.avm_waitrequest) begin
                    state_d = we_q ? DONE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (dm_io.avm_readdatavalid) begin
                    rdata_d = ext;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= F3_B;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                we_q     <= dm_io.req_we;
                funct3_q <= dm_io.req_funct3;
                addr_q   <= dm_io.req_addr;
                wdata_q  <= dm_io.req_wdata;
            end
        end
    end

    assign dm_io.start          = state_q == IDLE && dm_io.req_valid;
    assign dm_io.done           = state_q == DONE;
    assign dm_io.err            = err_q;
    assign dm_io.rdata_out      = rdata_q;
    assign dm_io.avm_address    = {addr_q[ADDR_W-1:2], 2'b00};
    assign dm_io.avm_byteenable = byte_en(funct3_q, addr_q[1:0]);
    assign dm_io.avm_writedata  = lane_data(funct3_q, wdata_q);

endmodule

// File: tb/tb_avalon_data_master.sv
// tb_avalon_data_master: randomized load/store traffic against a timeline reference model.
module tb_avalon_data_master;

    localparam int ADDR_W = 32;
    localparam int TO     = 8;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] exp_rdata = '0;
    logic [2:0]  valid_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    always #5 CLK = ~CLK;

    avalon_data_master_if #(.ADDR_W(ADDR_W)) bus ();

    avalon_data_master #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .dm_io(bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic bit bad(input logic [2:0] f3, input logic [31:0] a);
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << size_of(f3)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        int s = size_of(f3);
        return s == 1 ? 32'(wd[7:0]) * 32'h01010101 : s == 2 ? 32'(wd[15:0]) * 32'h00010001 : wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int s = size_of(f3);
        logic [63:0] v = ({32'b0, rd} >> (8 * (a % 4))) & ((64'd1 << (8 * s)) - 64'd1);
        if (!f3[2] && s < 4 && v >= (64'd1 << (8 * s - 1))) v = v - (64'd1 << (8 * s));
        return v[31:0];
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            bus.req_valid         = 1'b0;
            bus.avm_readdatavalid = 1'($urandom);
            bus.avm_readdata      = $urandom;
            #1;
            chk("idle_start", bus.start, 1'b0);
            chk("idle_done", bus.done, 1'b0);
            chk("idle_read", bus.avm_read, 1'b0);
        end
    endtask

    // w = waitrequest cycles, d = readdatavalid delay after accept, hold = keep req_valid high
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int w, input int d, input bit hold);
        bit mis = bad(f3, addr);
        int need = we ? w + 1 : w + 1 + d;
        bit ok = !mis && need <= TO - 1;
        int done_c = mis ? 1 : ok ? need + 1 : TO + 1;
        int cmd_end = mis ? 0 : (w + 1 < TO - 1 ? w + 1 : TO - 1);
        @(negedge CLK);
        bus.req_valid         = 1'b1;
        bus.req_we            = we;
        bus.req_funct3        = f3;
        bus.req_addr          = addr;
        bus.req_wdata         = wd;
        bus.avm_waitrequest   = 1'($urandom);
        bus.avm_readdatavalid = 1'($urandom);
        bus.avm_readdata      = $urandom;
        #1;
        chk("start", bus.start, 1'b1);
        chk("cap_read", bus.avm_read, 1'b0);
        chk("cap_write", bus.avm_write, 1'b0);
        chk("cap_done", bus.done, 1'b0);
        for (int c = 1; c <= done_c; c++) begin
            @(negedge CLK);
            bus.req_valid         = hold;
            bus.req_we            = 1'($urandom);
            bus.req_funct3        = 3'($urandom);
            bus.req_addr          = $urandom;
            bus.req_wdata         = $urandom;
            bus.avm_waitrequest   = c <= w;
            bus.avm_readdatavalid = (!we && c == w + 1 + d) ? 1'b1 : (c <= w + 1 ? 1'($urandom) : 1'b0);
            bus.avm_readdata      = (c == w + 1 + d) ? rd : $urandom;
            #1;
            chk("busy_start", bus.start, 1'b0);
            chk("read", bus.avm_read, !mis && !we && c <= cmd_end);
            chk("write", bus.avm_write, !mis && we && c <= cmd_end);
            if (c <= cmd_end) begin
                chk("address", bus.avm_address, {addr[31:2], 2'b00});
                chk("byteenable", bus.avm_byteenable, m_be(f3, addr));
                if (we) chk("writedata", bus.avm_writedata, m_wd(f3, wd));
            end
            chk("done", bus.done, c == done_c);
        end
        if (ok && !we) exp_rdata = m_load(f3, addr, rd);
        chk("err", bus.err, !ok);
        chk("rdata_out", bus.rdata_out, exp_rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST_N                 = 1'b1;
        bus.req_valid         = 1'b0;
        bus.req_we            = 1'b0;
        bus.req_funct3        = 3'b0;
        bus.req_addr          = '0;
        bus.req_wdata         = '0;
        bus.avm_readdata      = '0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("rst_read", bus.avm_read, 1'b0);
        chk("rst_write", bus.avm_write, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_rdata", bus.rdata_out, 32'h0);
        chk("rst_start", bus.start, 1'b0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 1'b0);
        chk("lw_lit", bus.rdata_out, 32'hDEADBEEF);
        do_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 1, 1'b0);
        chk("lb_lit", bus.rdata_out, 32'hFFFFFF80);
        do_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 1, 1'b0);
        chk("lbu_lit", bus.rdata_out, 32'h00000080);
        do_op(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 3, 1, 1'b0);
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 1'b0);
        chk("mis_err_lit", bus.err, 1'b1);
        chk("mis_rdata_lit", bus.rdata_out, 32'h00000080);
        do_op(1'b0, 3'b010, 32'h104, 32'h0, 32'h55AA55AA, 0, 99, 1'b0);
        do_op(1'b0, 3'b001, 32'h106, 32'h0, 32'h0, 12, 1, 1'b1);
        do_op(1'b1, 3'b000, 32'h107, 32'hA5, 32'h0, 10, 1, 1'b1);
        do_op(1'b0, 3'b101, 32'h10A, 32'h0, 32'h8001F00F, 2, 2, 1'b0);
        idle(2);

        for (int v = 0; v < 2; v++) begin
            @(negedge CLK);
            bus.req_valid       = 1'b1;
            bus.req_we          = 1'b0;
            bus.req_funct3      = 3'b010;
            bus.req_addr        = 32'h200;
            bus.avm_waitrequest = v == 0;
            @(negedge CLK);
            bus.req_valid         = 1'b0;
            bus.avm_readdatavalid = 1'b0;
            @(negedge CLK);
            #1;
            chk("pre_rst_read", bus.avm_read, v == 0);
            RST_N = 1'b0;
            #1;
            chk("mid_rst_read", bus.avm_read, 1'b0);
            chk("mid_rst_done", bus.done, 1'b0);
            chk("mid_rst_rdata", bus.rdata_out, 32'h0);
            exp_rdata = '0;
            @(negedge CLK);
            RST_N = 1'b1;
            do_op(1'b0, 3'b000, 32'h201, 32'h0, 32'h0000C300, 0, 1, 1'b0);
        end

        for (int i = 0; i < 300; i++) begin
            logic [2:0]  f3   = $urandom_range(0, 9) == 0 ? 3'($urandom) : valid_f3[$urandom_range(0, 4)];
            logic [31:0] addr = $urandom;
            int          w    = $urandom_range(0, 7) == 0 ? 9 : $urandom_range(0, 3);
            int          d    = $urandom_range(0, 7) == 0 ? 20 : $urandom_range(1, 4);
            bit          hold = 1'($urandom);
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            do_op(1'($urandom), f3, addr, $urandom, $urandom, w, d, hold);
            if (!hold && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
